// File: rtl/tnet_cmd_dispatch.sv
// tnet_cmd_dispatch: accepts local/network commands from the command coder,
// queues them in a small FIFO and serializes each one as four 32-bit TX words.
module tnet_cmd_dispatch #(
    parameter int unsigned FIFO_AW = 3
) (
    input  logic                c_clk_i,
    input  logic                c_rst_ni,
    input  logic                c_flush_i,
    input  logic [63:0]         header_i,
    input  logic [1:0][31:0]    data_i,
    input  logic                loc_cmd_req_i,
    output logic                loc_cmd_ack_o,
    input  logic                net_cmd_req_i,
    output logic                net_cmd_ack_o,
    output logic                tx_vld_o,
    input  logic                tx_rdy_i,
    output logic [31:0]         tx_dt_o,
    output logic                tx_last_o,
    output logic                tx_src_o,
    output logic [FIFO_AW:0]    fifo_cnt_o,
    output logic [15:0]         pkt_cnt_o
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CNT_W = FIFO_AW + 1;
    localparam int unsigned PL_W  = 128;
    localparam int unsigned ENT_W = PL_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    state_t               state;
    logic [ENT_W-1:0]     mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr;
    logic [FIFO_AW-1:0]   rd_ptr;
    logic [PL_W-1:0]      shadow;
    logic [1:0]           idx;

    logic                 full_c;
    logic                 empty_c;
    logic                 ack_guard_c;
    logic                 accept_c;
    logic                 accept_src_c;
    logic                 pop_c;
    logic                 beat_c;
    logic [ENT_W-1:0]     head_c;
    logic [1:0]           idx_nxt_c;

    // Word order within a packet: header high, header low, data[0], data[1].
    function automatic logic [31:0] word_sel(input logic [PL_W-1:0] pl, input logic [1:0] i);
        case (i)
            2'd0:    word_sel = pl[127:96];
            2'd1:    word_sel = pl[95:64];
            2'd2:    word_sel = pl[31:0];
            default: word_sel = pl[63:32];
        endcase
    endfunction

    // Accept qualification, FIFO status and serializer handshake decode.
    always_comb begin
        full_c       = (fifo_cnt_o == CNT_W'(DEPTH));
        empty_c      = (fifo_cnt_o == CNT_W'(0));
        // A registered ack means upstream has not yet dropped its req.
        ack_guard_c  = loc_cmd_ack_o | net_cmd_ack_o;
        accept_c     = (loc_cmd_req_i | net_cmd_req_i) & ~full_c & ~ack_guard_c & ~c_flush_i;
        accept_src_c = loc_cmd_req_i;
        pop_c        = (state == ST_LOAD) & ~c_flush_i;
        beat_c       = (state == ST_SEND) & tx_vld_o & tx_rdy_i;
        head_c       = mem[rd_ptr];
        idx_nxt_c    = idx + 2'd1;
    end

    // FIFO storage write; entry layout is {src, header, data[1], data[0]}.
    always_ff @(posedge c_clk_i) begin
        if (accept_c) begin
            mem[wr_ptr] <= {accept_src_c, header_i, data_i[1], data_i[0]};
        end
    end

    // Ack pulses, FIFO pointers and occupancy.
    always_ff @(posedge c_clk_i or negedge c_rst_ni) begin
        if (!c_rst_ni) begin
            loc_cmd_ack_o <= 1'b0;
            net_cmd_ack_o <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_cnt_o    <= '0;
        end else begin
            loc_cmd_ack_o <= accept_c & accept_src_c;
            net_cmd_ack_o <= accept_c & ~accept_src_c;
            if (c_flush_i) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_cnt_o <= '0;
            end else begin
                if (accept_c) begin
                    wr_ptr <= wr_ptr + FIFO_AW'(1);
                end
                if (pop_c) begin
                    rd_ptr <= rd_ptr + FIFO_AW'(1);
                end
                fifo_cnt_o <= fifo_cnt_o + CNT_W'(accept_c) - CNT_W'(pop_c);
            end
        end
    end

    // Serializer: load head into the shadow, then stream four words per packet.
    always_ff @(posedge c_clk_i or negedge c_rst_ni) begin
        if (!c_rst_ni) begin
            state     <= ST_IDLE;
            shadow    <= '0;
            idx       <= 2'd0;
            tx_vld_o  <= 1'b0;
            tx_dt_o   <= 32'd0;
            tx_last_o <= 1'b0;
            tx_src_o  <= 1'b0;
            pkt_cnt_o <= 16'd0;
        end else if (c_flush_i) begin
            state     <= ST_IDLE;
            idx       <= 2'd0;
            tx_vld_o  <= 1'b0;
            tx_last_o <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!empty_c) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    shadow    <= head_c[PL_W-1:0];
                    tx_src_o  <= head_c[PL_W];
                    tx_dt_o   <= word_sel(head_c[PL_W-1:0], 2'd0);
                    tx_last_o <= 1'b0;
                    tx_vld_o  <= 1'b1;
                    idx       <= 2'd0;
                    state     <= ST_SEND;
                end
                ST_SEND: begin
                    if (beat_c) begin
                        if (idx == 2'd3) begin
                            pkt_cnt_o <= pkt_cnt_o + 16'd1;
                            tx_vld_o  <= 1'b0;
                            tx_last_o <= 1'b0;
                            idx       <= 2'd0;
                            state     <= empty_c ? ST_IDLE : ST_LOAD;
                        end else begin
                            idx       <= idx_nxt_c;
                            tx_dt_o   <= word_sel(shadow, idx_nxt_c);
                            tx_last_o <= (idx_nxt_c == 2'd3);
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    tx_vld_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tnet_cmd_dispatch.sv
// Bench for tnet_cmd_dispatch: random commands and TX backpressure checked
// against a queue-based packet model.
module tb_tnet_cmd_dispatch;

    logic               c_clk_i;
    logic               c_rst_ni;
    logic               c_flush_i;
    logic [63:0]        header_i;
    logic [1:0][31:0]   data_i;
    logic               loc_cmd_req_i;
    logic               loc_cmd_ack_o;
    logic               net_cmd_req_i;
    logic               net_cmd_ack_o;
    logic               tx_vld_o;
    logic               tx_rdy_i;
    logic [31:0]        tx_dt_o;
    logic               tx_last_o;
    logic               tx_src_o;
    logic [3:0]         fifo_cnt_o;
    logic [15:0]        pkt_cnt_o;

    tnet_cmd_dispatch #(.FIFO_AW(3)) dut (
        .c_clk_i       (c_clk_i),
        .c_rst_ni      (c_rst_ni),
        .c_flush_i     (c_flush_i),
        .header_i      (header_i),
        .data_i        (data_i),
        .loc_cmd_req_i (loc_cmd_req_i),
        .loc_cmd_ack_o (loc_cmd_ack_o),
        .net_cmd_req_i (net_cmd_req_i),
        .net_cmd_ack_o (net_cmd_ack_o),
        .tx_vld_o      (tx_vld_o),
        .tx_rdy_i      (tx_rdy_i),
        .tx_dt_o       (tx_dt_o),
        .tx_last_o     (tx_last_o),
        .tx_src_o      (tx_src_o),
        .fifo_cnt_o    (fifo_cnt_o),
        .pkt_cnt_o     (pkt_cnt_o)
    );

    initial c_clk_i = 1'b0;
    always #5 c_clk_i = ~c_clk_i;

    int n_cmp = 0;
    int n_err = 0;

    // Expected TX words, each {src, last, word}.
    logic [33:0] exp_q[$];
    int          mdl_pkts = 0;
    int          loc_issued = 0;
    int          net_issued = 0;
    int          loc_ack_seen = 0;
    int          net_ack_seen = 0;

    logic        prev_stall = 1'b0;
    logic [33:0] prev_word = '0;
    logic        prev_loc_ack = 1'b0;
    logic        prev_net_ack = 1'b0;
    bit          done;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_push(input bit src, input logic [63:0] h,
                                       input logic [31:0] d0, input logic [31:0] d1);
        exp_q.push_back({src, 1'b0, h[63:32]});
        exp_q.push_back({src, 1'b0, h[31:0]});
        exp_q.push_back({src, 1'b0, d0});
        exp_q.push_back({src, 1'b1, d1});
        if (src) loc_issued++;
        else     net_issued++;
    endfunction

    // Beat scoreboard, stall stability and ack pulse checks.
    always @(negedge c_clk_i) begin
        if (!c_rst_ni) begin
            prev_stall   = 1'b0;
            prev_loc_ack = 1'b0;
            prev_net_ack = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_vld", 64'(tx_vld_o), 64'd1);
                chk("stall_word", 64'({tx_src_o, tx_last_o, tx_dt_o}), 64'(prev_word));
            end
            if (tx_vld_o && tx_rdy_i && !c_flush_i) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'({tx_src_o, tx_last_o, tx_dt_o}), 64'd0);
                end else begin
                    logic [33:0] e;
                    e = exp_q.pop_front();
                    chk("beat", 64'({tx_src_o, tx_last_o, tx_dt_o}), 64'(e));
                    if (e[32]) mdl_pkts++;
                end
            end
            prev_stall = tx_vld_o && !tx_rdy_i && !c_flush_i;
            prev_word  = {tx_src_o, tx_last_o, tx_dt_o};
            if (loc_cmd_ack_o) begin
                loc_ack_seen++;
                chk("loc_ack_pulse", 64'(prev_loc_ack), 64'd0);
            end
            if (net_cmd_ack_o) begin
                net_ack_seen++;
                chk("net_ack_pulse", 64'(prev_net_ack), 64'd0);
            end
            prev_loc_ack = loc_cmd_ack_o;
            prev_net_ack = net_cmd_ack_o;
        end
    end

    // Raise one request with a random payload and hold it until acked.
    task automatic issue(input bit src, input int max_wait);
        logic [63:0] h;
        logic [31:0] d0, d1;
        bit ok;
        h  = {$urandom, $urandom};
        d0 = $urandom;
        d1 = $urandom;
        header_i = h;
        data_i   = {d1, d0};
        if (src) loc_cmd_req_i = 1'b1;
        else     net_cmd_req_i = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < max_wait; i++) begin
            @(posedge c_clk_i); #1;
            if (src ? loc_cmd_ack_o : net_cmd_ack_o) begin
                ok = 1'b1;
                break;
            end
        end
        loc_cmd_req_i = 1'b0;
        net_cmd_req_i = 1'b0;
        if (ok) model_push(src, h, d0, d1);
        else    chk("ack_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_drain(input int max_cyc);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge c_clk_i); #1;
            if (exp_q.size() == 0 && !tx_vld_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge c_clk_i); #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int loc_cyc, net_cyc, cyc;
        logic [15:0] pk;
        bit acked;
        logic [63:0] h_loc, h_net;
        logic [31:0] dl0, dl1, dn0, dn1;

        c_rst_ni      = 1'b0;
        c_flush_i     = 1'b0;
        header_i      = '0;
        data_i        = '0;
        loc_cmd_req_i = 1'b0;
        net_cmd_req_i = 1'b0;
        tx_rdy_i      = 1'b1;
        #12;
        chk("rst_acks", 64'({loc_cmd_ack_o, net_cmd_ack_o}), 64'd0);
        chk("rst_tx", 64'({tx_vld_o, tx_last_o, tx_src_o, tx_dt_o}), 64'd0);
        chk("rst_cnts", 64'({fifo_cnt_o, pkt_cnt_o}), 64'd0);
        #6 c_rst_ni = 1'b1;
        wait_cycles(3);

        // Directed single local command with cycle-exact latency.
        header_i      = 64'h0123456789ABCDEF;
        data_i        = {32'h22222222, 32'h11111111};
        loc_cmd_req_i = 1'b1;
        @(posedge c_clk_i); #1;
        chk("t1_ack_p1", 64'(loc_cmd_ack_o), 64'd1);
        loc_cmd_req_i = 1'b0;
        model_push(1'b1, 64'h0123456789ABCDEF, 32'h11111111, 32'h22222222);
        @(posedge c_clk_i); #1;
        chk("t1_ack_p2", 64'(loc_cmd_ack_o), 64'd0);
        chk("t1_vld_p2", 64'(tx_vld_o), 64'd0);
        @(posedge c_clk_i); #1;
        chk("t1_w0", 64'({tx_vld_o, tx_src_o, tx_last_o, tx_dt_o}), {31'd0, 3'b110, 32'h01234567});
        @(posedge c_clk_i); #1;
        chk("t1_w1", 64'({tx_vld_o, tx_src_o, tx_last_o, tx_dt_o}), {31'd0, 3'b110, 32'h89ABCDEF});
        @(posedge c_clk_i); #1;
        chk("t1_w2", 64'({tx_vld_o, tx_src_o, tx_last_o, tx_dt_o}), {31'd0, 3'b110, 32'h11111111});
        @(posedge c_clk_i); #1;
        chk("t1_w3", 64'({tx_vld_o, tx_src_o, tx_last_o, tx_dt_o}), {31'd0, 3'b111, 32'h22222222});
        @(posedge c_clk_i); #1;
        chk("t1_end_vld", 64'(tx_vld_o), 64'd0);
        chk("t1_pkt_cnt", 64'(pkt_cnt_o), 64'd1);
        wait_cycles(2);

        // Both requests together: local wins, network follows at least 2 cycles later.
        h_loc = {$urandom, $urandom}; dl0 = $urandom; dl1 = $urandom;
        h_net = {$urandom, $urandom}; dn0 = $urandom; dn1 = $urandom;
        header_i = h_loc;
        data_i   = {dl1, dl0};
        loc_cmd_req_i = 1'b1;
        net_cmd_req_i = 1'b1;
        loc_cyc = -1;
        net_cyc = -1;
        for (cyc = 1; cyc <= 20; cyc++) begin
            @(posedge c_clk_i); #1;
            if (loc_cmd_ack_o) begin
                chk("dual_net_not_first", 64'(net_cmd_ack_o), 64'd0);
                loc_cyc = cyc;
                loc_cmd_req_i = 1'b0;
                model_push(1'b1, h_loc, dl0, dl1);
                header_i = h_net;
                data_i   = {dn1, dn0};
            end
            if (net_cmd_ack_o) begin
                net_cyc = cyc;
                net_cmd_req_i = 1'b0;
                model_push(1'b0, h_net, dn0, dn1);
                break;
            end
        end
        loc_cmd_req_i = 1'b0;
        net_cmd_req_i = 1'b0;
        chk("dual_loc_ack_cyc", 64'(loc_cyc), 64'd1);
        chk("dual_net_gap_ok", 64'((net_cyc >= 0) && (net_cyc - loc_cyc >= 2)), 64'd1);
        wait_drain(100);

        // Fill under backpressure; one command already sits in the serializer.
        tx_rdy_i = 1'b0;
        for (int k = 0; k < 9; k++) issue(1'($urandom_range(0, 1)), 20);
        wait_cycles(1);
        chk("full_cnt", 64'(fifo_cnt_o), 64'd8);
        header_i = {$urandom, $urandom};
        data_i   = {$urandom, $urandom};
        h_net = header_i; dn0 = data_i[0]; dn1 = data_i[1];
        net_cmd_req_i = 1'b1;
        acked = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge c_clk_i); #1;
            if (net_cmd_ack_o) acked = 1'b1;
        end
        chk("full_no_ack", 64'(acked), 64'd0);
        chk("full_cnt_held", 64'(fifo_cnt_o), 64'd8);
        tx_rdy_i = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge c_clk_i); #1;
            if (net_cmd_ack_o) begin
                acked = 1'b1;
                break;
            end
        end
        net_cmd_req_i = 1'b0;
        chk("full_late_ack", 64'(acked), 64'd1);
        if (acked) model_push(1'b0, h_net, dn0, dn1);
        wait_drain(300);
        chk("full_pkt_cnt", 64'(pkt_cnt_o), 64'(mdl_pkts));

        // 20 random packets with random TX backpressure.
        pk = pkt_cnt_o;
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 20; k++) issue(1'($urandom_range(0, 1)), 300);
                wait_drain(3000);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge c_clk_i); #1;
                    tx_rdy_i = ($urandom_range(0, 3) != 0);
                end
            end
        join
        tx_rdy_i = 1'b1;
        chk("rand_pkt_delta", 64'(16'(pkt_cnt_o - pk)), 64'd20);
        chk("rand_pkt_model", 64'(pkt_cnt_o), 64'(mdl_pkts));

        // Flush after two words of a packet with three more queued.
        tx_rdy_i = 1'b0;
        for (int k = 0; k < 4; k++) issue(1'($urandom_range(0, 1)), 20);
        acked = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (tx_vld_o && fifo_cnt_o == 4'd3) begin
                acked = 1'b1;
                break;
            end
            @(posedge c_clk_i); #1;
        end
        chk("flush_setup", 64'(acked), 64'd1);
        tx_rdy_i = 1'b1;
        @(posedge c_clk_i); #1;
        @(posedge c_clk_i); #1;
        pk = pkt_cnt_o;
        chk("flush_pre_last", 64'(tx_last_o), 64'd0);
        tx_rdy_i  = 1'b0;
        c_flush_i = 1'b1;
        exp_q.delete();
        @(posedge c_clk_i); #1;
        c_flush_i = 1'b0;
        chk("flush_vld", 64'(tx_vld_o), 64'd0);
        chk("flush_cnt", 64'(fifo_cnt_o), 64'd0);
        chk("flush_pkt", 64'(pkt_cnt_o), 64'(pk));
        chk("flush_last", 64'(tx_last_o), 64'd0);
        tx_rdy_i = 1'b1;
        wait_cycles(6);
        chk("flush_idle_vld", 64'(tx_vld_o), 64'd0);
        chk("flush_idle_pkt", 64'(pkt_cnt_o), 64'(pk));

        // Async reset between edges while a packet is in SEND.
        tx_rdy_i = 1'b0;
        issue(1'b1, 20);
        acked = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge c_clk_i); #1;
            if (tx_vld_o) begin
                acked = 1'b1;
                break;
            end
        end
        chk("rstm_setup", 64'(acked), 64'd1);
        #2 c_rst_ni = 1'b0;
        #1;
        chk("rstm_tx", 64'({tx_vld_o, tx_last_o, tx_src_o, tx_dt_o}), 64'd0);
        chk("rstm_acks", 64'({loc_cmd_ack_o, net_cmd_ack_o}), 64'd0);
        chk("rstm_cnts", 64'({fifo_cnt_o, pkt_cnt_o}), 64'd0);
        exp_q.delete();
        mdl_pkts = 0;
        @(negedge c_clk_i); #2;
        c_rst_ni = 1'b1;
        tx_rdy_i = 1'b1;
        acked = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge c_clk_i); #1;
            if (loc_cmd_ack_o || net_cmd_ack_o) acked = 1'b1;
        end
        chk("rstm_no_ack", 64'(acked), 64'd0);
        issue(1'($urandom_range(0, 1)), 20);
        wait_drain(50);
        chk("rstm_pkt_cnt", 64'(pkt_cnt_o), 64'd1);
        chk("rstm_pkt_model", 64'(mdl_pkts), 64'd1);

        chk("loc_ack_count", 64'(loc_ack_seen), 64'(loc_issued));
        chk("net_ack_count", 64'(net_ack_seen), 64'(net_issued));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
